gray_counter_conv: RTL and testbench
====================================

Name: gray_counter_conv

Overview:
- Parametrised successor to the 4-bit combinational binary-to-Gray encoder.
- An N-bit up/down counter that keeps binary and Gray state in registers and drives them out, with synchronous clear, parallel load and a terminal-count pulse.
- Also has an independent one-cycle pipelined converter channel that does binary-to-Gray or Gray-to-binary, selected per transaction.
- Used for clock-domain-crossing pointers (FIFOs) and encoder position logic.

Parameters:
- WIDTH, 4, bit width of the counter, the Gray code and the converter data; legal range 2..32.
- RST_VAL, 0, binary value loaded on reset and on clr; must fit in WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear to RST_VAL
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  binary value for load
- cnt_bin  out  WIDTH  registered binary count
- cnt_gray  out  WIDTH  registered Gray count, always equal to gray(cnt_bin)
- tc  out  1  registered one-cycle pulse on wrap-around
- in_vld  in  1  converter request valid
- in_mode  in  1  0 = binary-to-Gray, 1 = Gray-to-binary
- in_data  in  WIDTH  converter input
- out_vld  out  1  converter result valid
- out_data  out  WIDTH  converter result

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - cnt_bin = RST_VAL, cnt_gray = gray(RST_VAL).
  - tc = 0, out_vld = 0, out_data = 0.
  - An in-flight conversion is dropped.
- Release of rst_n is synchronous to clk; the first update happens on the first rising edge with rst_n high.
- Encoding: gray = b ^ (b >> 1); MSB passes through.
- Decoding: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i down to 0.
- Counter priority per cycle: clr > load > en > hold.
  - clr: cnt_bin <= RST_VAL.
  - load: cnt_bin <= load_val.
  - en & up: cnt_bin <= cnt_bin + 1, modulo 2^WIDTH.
  - en & !up: cnt_bin <= cnt_bin - 1, modulo 2^WIDTH.
  - Otherwise both registers hold.
- cnt_gray is registered from gray(next cnt_bin) in the same edge. It is never derived combinationally from the cnt_bin output, so the output is glitch-free and safe to synchronise.
- Invariant: on every en step (no clr/load), exactly one bit of cnt_gray changes. clr and load may change several bits.
- Wrap-around:
  - Up from all-ones goes to 0.
  - Down from 0 goes to all-ones.
  - tc = 1 for exactly the cycle after the wrapping edge; 0 otherwise.
  - tc is not asserted by clr or load, even if they produce 0 or all-ones.
- Simultaneous clr and load: clr wins; load_val is ignored; tc = 0.
- Converter channel:
  - Independent of the counter; no backpressure.
  - in_vld sampled high -> next cycle out_vld = 1 and out_data = convert(in_data, in_mode).
  - in_vld low -> next cycle out_vld = 0 and out_data holds its last value.
  - Back-to-back requests give one result per cycle. Latency is exactly 1 cycle; throughput is 1 per cycle.
- Gray-to-binary decode is a WIDTH-deep XOR chain. It must close timing at WIDTH = 32 in one cycle; no extra pipeline stage is permitted.
- Data inputs with x/z while the matching valid or enable is low must not propagate to outputs.

Decomposition:
- Package gray_pkg:
  - Function bin2gray(b) and function gray2bin(g), sized by a WIDTH argument (or package max width, 32, plus masking).
  - Constant MODE_B2G = 0, MODE_G2B = 1.
- Sub-module gray_conv (pure combinational, parameter WIDTH; ports mode, din, dout).
  - Instantiated once for the converter channel.
  - The counter's next-Gray path calls bin2gray directly.
- Top gray_counter_conv holds the counter registers, the tc flop and the converter output registers.

Test Plan (WIDTH=4, RST_VAL=0 unless noted):
1. Reset, then en=1, up=1 for 16 cycles -> cnt_bin 0..15 then 0; cnt_gray 0000,0001,0011,0010,0110,...,1000 then 0000; exactly one Gray bit changes per step; tc=1 only in the cycle after 1111->0000.
2. From cnt_bin=0: en=1, up=0 -> cnt_bin=1111, cnt_gray=1000, tc=1 for one cycle; next step gives 1110 / 1001 with tc=0.
3. load=1, load_val=1010 with en=1 -> cnt_bin=1010, cnt_gray=1111, tc=0. Next cycle clr=1 and load=1 together -> cnt_bin=0000, cnt_gray=0000, tc=0.
4. Back-to-back converter requests:
   - mode 0, data 0110 -> out 0101.
   - mode 1, data 0101 -> out 0110.
   - mode 1, data 1000 -> out 1111.
   - out_vld is high for 3 consecutive cycles, each result 1 cycle after its input; then in_vld=0 gives out_vld=0 with out_data held at 1111.
5. Drop rst_n mid-count (cnt_bin=0111) while a conversion is in flight -> outputs go to reset values immediately, without waiting for clk; after release the count restarts from 0.
6. WIDTH=8, RST_VAL=8'hFE: reset, then 2 up steps -> cnt_bin FE, FF, 00; tc pulses once; cnt_gray 81, 80, 00.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and converter mode encodings.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Converter channel mode select values.
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Binary to Gray. Callers zero-extend narrower values; the MSB passes through unchanged.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary. Each binary bit is the XOR of all Gray bits at or above it.
  // A log-depth prefix XOR computes this instead of a 32-deep ripple chain, so the
  // decode fits in one cycle at full width. Zero-extended inputs decode correctly
  // because the zero upper bits contribute nothing to the prefix.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational binary<->Gray converter; mode selects the direction.
module gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Select the conversion direction; both paths work on a zero-extended copy of din.
  always_comb begin
    dout = '0;
    if (mode == MODE_G2B) begin
      dout = WIDTH'(gray2bin(MAX_WIDTH'(din)));
    end else begin
      dout = WIDTH'(bin2gray(MAX_WIDTH'(din)));
    end
  end

endmodule

// File: rtl/gray_counter_conv.sv
// Up/down binary counter with a registered Gray shadow and a wrap pulse, plus an
// independent one-cycle binary<->Gray conversion channel.
module gray_counter_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             tc,
  input  logic             in_vld,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] RstBin  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RstGray = WIDTH'(bin2gray(MAX_WIDTH'(RST_VAL)));

  logic [WIDTH-1:0] cnt_bin_q, cnt_bin_d;
  logic [WIDTH-1:0] cnt_gray_q, cnt_gray_d;
  logic             tc_q, tc_d;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] conv_dout;

  // Next count by priority clr > load > en; tc only on an en step that wraps.
  always_comb begin
    cnt_bin_d = cnt_bin_q;
    tc_d      = 1'b0;
    if (clr) begin
      cnt_bin_d = RstBin;
    end else if (load) begin
      cnt_bin_d = load_val;
    end else if (en) begin
      if (up) begin
        cnt_bin_d = cnt_bin_q + WIDTH'(1);
        tc_d      = &cnt_bin_q;
      end else begin
        cnt_bin_d = cnt_bin_q - WIDTH'(1);
        tc_d      = ~|cnt_bin_q;
      end
    end
    // Gray is registered from the next binary value, never decoded from the output flops.
    cnt_gray_d = WIDTH'(bin2gray(MAX_WIDTH'(cnt_bin_d)));
  end

  // Counter, Gray shadow and wrap pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bin_q  <= RstBin;
      cnt_gray_q <= RstGray;
      tc_q       <= 1'b0;
    end else begin
      cnt_bin_q  <= cnt_bin_d;
      cnt_gray_q <= cnt_gray_d;
      tc_q       <= tc_d;
    end
  end

  gray_conv #(
    .WIDTH (WIDTH)
  ) u_conv (
    .mode (in_mode),
    .din  (in_data),
    .dout (conv_dout)
  );

  // Result register only captures on a valid request so idle data cannot leak out.
  always_comb begin
    out_data_d = out_data_q;
    if (in_vld) begin
      out_data_d = conv_dout;
    end
  end

  // Converter output stage: one result per cycle, one cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= in_vld;
      out_data_q <= out_data_d;
    end
  end

  assign cnt_bin  = cnt_bin_q;
  assign cnt_gray = cnt_gray_q;
  assign tc       = tc_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_gray_counter_conv.sv
// Directed bench for gray_counter_conv: 4-bit default instance plus an 8-bit,
// RST_VAL=8'hFE instance for the non-zero reset wrap case.
module tb_gray_counter_conv;

  logic       clk;
  logic       rst_n;
  logic       en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt_bin, cnt_gray;
  logic       tc;
  logic       in_vld, in_mode;
  logic [3:0] in_data;
  logic       out_vld;
  logic [3:0] out_data;

  logic       en8, up8, clr8, load8;
  logic [7:0] load_val8;
  logic [7:0] cnt_bin8, cnt_gray8;
  logic       tc8;
  logic       in_vld8, in_mode8;
  logic [7:0] in_data8;
  logic       out_vld8;
  logic [7:0] out_data8;

  int n_vec;
  int n_err;

  gray_counter_conv #(
    .WIDTH   (4),
    .RST_VAL (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .cnt_bin  (cnt_bin),
    .cnt_gray (cnt_gray),
    .tc       (tc),
    .in_vld   (in_vld),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_data (out_data)
  );

  gray_counter_conv #(
    .WIDTH   (8),
    .RST_VAL (8'hFE)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en8),
    .up       (up8),
    .clr      (clr8),
    .load     (load8),
    .load_val (load_val8),
    .cnt_bin  (cnt_bin8),
    .cnt_gray (cnt_gray8),
    .tc       (tc8),
    .in_vld   (in_vld8),
    .in_mode  (in_mode8),
    .in_data  (in_data8),
    .out_vld  (out_vld8),
    .out_data (out_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed 4-bit Gray sequence for counts 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    logic [3:0] prev_gray;
    n_vec = 0;
    n_err = 0;
    en = 0; up = 1; clr = 0; load = 0; load_val = '0;
    in_vld = 0; in_mode = 0; in_data = '0;
    en8 = 0; up8 = 1; clr8 = 0; load8 = 0; load_val8 = '0;
    in_vld8 = 0; in_mode8 = 0; in_data8 = '0;

    // Reset state.
    rst_n = 1'b0;
    #12;
    check("rst_bin", cnt_bin, 4'h0);
    check("rst_gray", cnt_gray, 4'h0);
    check("rst_tc", tc, 1'b0);
    check("rst_vld", out_vld, 1'b0);
    check("rst_data", out_data, 4'h0);
    tick();
    rst_n = 1'b1;

    // Count up through a full wrap.
    en = 1; up = 1;
    prev_gray = cnt_gray;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("up_bin", cnt_bin, 32'(i % 16));
      check("up_gray", cnt_gray, gray_tab[i % 16]);
      check("up_onebit", $countones(prev_gray ^ cnt_gray), 1);
      check("up_tc", tc, (i == 16) ? 1'b1 : 1'b0);
      prev_gray = cnt_gray;
    end

    // Count down from zero wraps to all-ones.
    up = 0;
    tick();
    check("dn_wrap_bin", cnt_bin, 4'hF);
    check("dn_wrap_gray", cnt_gray, 4'h8);
    check("dn_wrap_tc", tc, 1'b1);
    tick();
    check("dn_bin", cnt_bin, 4'hE);
    check("dn_gray", cnt_gray, 4'h9);
    check("dn_tc", tc, 1'b0);

    // Hold when idle.
    en = 0;
    tick();
    check("hold_bin", cnt_bin, 4'hE);
    check("hold_gray", cnt_gray, 4'h9);

    // Load beats en; clr beats load; neither raises tc.
    en = 1; up = 1; load = 1; load_val = 4'hA;
    tick();
    check("ld_bin", cnt_bin, 4'hA);
    check("ld_gray", cnt_gray, 4'hF);
    check("ld_tc", tc, 1'b0);
    clr = 1;
    tick();
    check("clrld_bin", cnt_bin, 4'h0);
    check("clrld_gray", cnt_gray, 4'h0);
    check("clrld_tc", tc, 1'b0);
    clr = 0; load_val = 4'hF;
    tick();
    check("ld_ones_bin", cnt_bin, 4'hF);
    check("ld_ones_tc", tc, 1'b0);
    load = 0; en = 0; load_val = 'x;
    tick();
    check("ldx_bin", cnt_bin, 4'hF);
    check("ldx_tc", tc, 1'b0);

    // Back-to-back converter requests.
    in_vld = 1; in_mode = 0; in_data = 4'b0110;
    tick();
    check("cv0_vld", out_vld, 1'b1);
    check("cv0_data", out_data, 4'b0101);
    in_mode = 1; in_data = 4'b0101;
    tick();
    check("cv1_vld", out_vld, 1'b1);
    check("cv1_data", out_data, 4'b0110);
    in_mode = 1; in_data = 4'b1000;
    tick();
    check("cv2_vld", out_vld, 1'b1);
    check("cv2_data", out_data, 4'b1111);
    in_vld = 0; in_data = 'x;
    tick();
    check("cv_idle_vld", out_vld, 1'b0);
    check("cv_idle_data", out_data, 4'b1111);
    in_vld = 1; in_mode = 1; in_data = 4'b1011;
    tick();
    check("cv3_data", out_data, 4'b1101);
    in_vld = 0; in_data = '0;

    // Asynchronous reset mid-count with a conversion in flight.
    clr = 1;
    tick();
    clr = 0; en = 1; up = 1;
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_bin", cnt_bin, 4'h7);
    check("pre_rst_gray", cnt_gray, 4'h4);
    in_vld = 1; in_mode = 0; in_data = 4'h3;
    tick();
    check("pre_rst_vld", out_vld, 1'b1);
    check("pre_rst_data", out_data, 4'h2);
    in_data = 4'h5;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bin", cnt_bin, 4'h0);
    check("arst_gray", cnt_gray, 4'h0);
    check("arst_tc", tc, 1'b0);
    check("arst_vld", out_vld, 1'b0);
    check("arst_data", out_data, 4'h0);
    in_vld = 0;
    tick();
    check("arst_hold_bin", cnt_bin, 4'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_bin", cnt_bin, 4'h1);
    check("post_rst_gray", cnt_gray, 4'h1);
    check("post_rst_vld", out_vld, 1'b0);
    en = 0;

    // 8-bit instance with non-zero reset value.
    rst_n = 1'b0;
    #1;
    check("w8_rst_bin", cnt_bin8, 8'hFE);
    check("w8_rst_gray", cnt_gray8, 8'h81);
    check("w8_rst_tc", tc8, 1'b0);
    tick();
    rst_n = 1'b1;
    en8 = 1; up8 = 1;
    tick();
    check("w8_s1_bin", cnt_bin8, 8'hFF);
    check("w8_s1_gray", cnt_gray8, 8'h80);
    check("w8_s1_tc", tc8, 1'b0);
    tick();
    check("w8_s2_bin", cnt_bin8, 8'h00);
    check("w8_s2_gray", cnt_gray8, 8'h00);
    check("w8_s2_tc", tc8, 1'b1);
    en8 = 0;
    tick();
    check("w8_s3_bin", cnt_bin8, 8'h00);
    check("w8_s3_tc", tc8, 1'b0);
    clr8 = 1;
    tick();
    check("w8_clr_bin", cnt_bin8, 8'hFE);
    check("w8_clr_gray", cnt_gray8, 8'h81);
    clr8 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
